// File: rtl/maindec_stage.sv
// rtl/maindec_stage.sv - registered RV32I main decoder stage with stall/flush and illegal-op trap
// Optional auipc decode is enabled by defining MAINDEC_AUIPC_EN.
module maindec_stage #(
    parameter int OP_WIDTH = 7,
    parameter int TAG_W    = 32,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAG_W-1:0]    out_tag,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                Jump,
    output logic                Branch,
    output logic                ALUSrc,
    output logic                ALUSrcA,
    output logic [1:0]          ResultSrc,
    output logic [2:0]          ImmSrc,
    output logic [1:0]          ALUOp,
    output logic                trap,
    input  logic                trap_ack,
    output logic [CNT_W-1:0]    ill_count
);

    localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(7'b0000000);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_B    = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_I    = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_JALR = OP_WIDTH'(7'b1100111);
`ifdef MAINDEC_AUIPC_EN
    localparam logic [OP_WIDTH-1:0] OP_AUIPC = OP_WIDTH'(7'b0010111);
`endif

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [11:0]        ctrl_q, ctrl_d, ctrl_dec;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dec_illegal;
    logic               accept;
    logic               alu_src_a_dec;

    // Control word: RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ImmSrc, ALUOp
    always_comb begin
        ctrl_dec      = '0;
        dec_illegal   = 1'b0;
        alu_src_a_dec = 1'b0;
        case (op)
            OP_NOP:   ctrl_dec = 12'b0_00_0_0_0_0_000_00;
            OP_LW:    ctrl_dec = 12'b1_01_0_0_0_1_000_00;
            OP_SW:    ctrl_dec = 12'b0_00_1_0_0_1_001_00;
            OP_R:     ctrl_dec = 12'b1_00_0_0_0_0_000_10;
            OP_B:     ctrl_dec = 12'b0_00_0_0_1_0_010_01;
            OP_I:     ctrl_dec = 12'b1_00_0_0_0_1_000_10;
            OP_LUI:   ctrl_dec = 12'b1_00_0_0_0_1_100_11;
            OP_JAL:   ctrl_dec = 12'b1_10_0_1_0_0_011_00;
            OP_JALR:  ctrl_dec = 12'b1_10_0_1_0_1_000_00;
`ifdef MAINDEC_AUIPC_EN
            OP_AUIPC: begin
                ctrl_dec      = 12'b1_00_0_0_0_1_100_00;
                alu_src_a_dec = 1'b1;
            end
`endif
            default:  dec_illegal = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && dec_illegal) state_d = TRAP;
            TRAP:    if (trap_ack || flush)     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        trap     = (state_q == TRAP);
        in_ready = (state_q == RUN) && (!out_valid_q || out_ready) && !flush;
    end

    assign accept = in_valid && in_ready;

    // Illegal ops still load the register (zero controls, their tag) but leave a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
        end else if (accept) begin
            out_valid_d = !dec_illegal;
            ctrl_d      = ctrl_dec;
            tag_d       = in_tag;
            if (dec_illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef MAINDEC_AUIPC_EN
    logic alu_src_a_q, alu_src_a_d;

    always_comb begin
        alu_src_a_d = alu_src_a_q;
        if (flush)       alu_src_a_d = 1'b0;
        else if (accept) alu_src_a_d = alu_src_a_dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_src_a_q <= 1'b0;
        else        alu_src_a_q <= alu_src_a_d;
    end

    assign ALUSrcA = alu_src_a_q;
`else
    assign ALUSrcA = alu_src_a_dec;
`endif

    assign {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ImmSrc, ALUOp} = ctrl_q;
    assign out_valid = out_valid_q;
    assign out_tag   = tag_q;
    assign ill_count = cnt_q;

endmodule

// File: tb/tb_maindec_stage.sv
// tb/tb_maindec_stage.sv - randomized scoreboard bench for maindec_stage
module tb_maindec_stage;

    localparam int TAG_W = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, flush, out_valid, out_ready;
    logic [6:0]       op;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             RegWrite, MemWrite, Jump, Branch, ALUSrc, ALUSrcA;
    logic [1:0]       ResultSrc, ALUOp;
    logic [2:0]       ImmSrc;
    logic             trap, trap_ack;
    logic [CNT_W-1:0] ill_count;
    logic [12:0]      dut_cw;

    always #5 clk = ~clk;

    maindec_stage #(.OP_WIDTH(7), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Jump(Jump), .Branch(Branch), .ALUSrc(ALUSrc),
        .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp),
        .trap(trap), .trap_ack(trap_ack), .ill_count(ill_count)
    );

    assign dut_cw = {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ImmSrc, ALUOp, ALUSrcA};

    typedef struct packed {
        logic [12:0]      cw;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit         m_occ, m_trap;
    int         m_cnt;
    logic       p_iv, p_fl, p_ordy, p_ack, p_rdy;
    logic [6:0] p_op;
    logic [TAG_W-1:0] p_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {legal, RegWrite/ResultSrc/MemWrite/Jump/Branch/ALUSrc/ImmSrc/ALUOp/ALUSrcA}
    function automatic logic [13:0] ref_decode(input logic [6:0] o);
        case (o)
            7'b0000000: return {1'b1, 13'b0};
            7'b0000011: return {1'b1, 13'b1_01_0_0_0_1_000_00_0};
            7'b0100011: return {1'b1, 13'b0_00_1_0_0_1_001_00_0};
            7'b0110011: return {1'b1, 13'b1_00_0_0_0_0_000_10_0};
            7'b1100011: return {1'b1, 13'b0_00_0_0_1_0_010_01_0};
            7'b0010011: return {1'b1, 13'b1_00_0_0_0_1_000_10_0};
            7'b0110111: return {1'b1, 13'b1_00_0_0_0_1_100_11_0};
            7'b1101111: return {1'b1, 13'b1_10_0_1_0_0_011_00_0};
            7'b1100111: return {1'b1, 13'b1_10_0_1_0_1_000_00_0};
`ifdef MAINDEC_AUIPC_EN
            7'b0010111: return {1'b1, 13'b1_00_0_0_0_1_100_00_1};
`endif
            default:    return 14'b0;
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] tbl [10];
        tbl = '{7'b0000000, 7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                7'b0010011, 7'b0110111, 7'b1101111, 7'b1100111, 7'b0010111};
        if ($urandom_range(0, 7) != 0) return tbl[$urandom_range(0, 9)];
        return 7'($urandom);
    endfunction

    // One cycle: retire the previous cycle's inputs into the model, check, then drive new inputs.
    task automatic step(input logic iv, input logic [6:0] o, input logic [TAG_W-1:0] t,
                        input logic fl, input logic ordy, input logic ack);
        logic [13:0] r;
        @(negedge clk);
        if (p_fl) begin
            if (m_occ) void'(sb.pop_front());
            m_occ  = 1'b0;
            m_trap = 1'b0;
        end else begin
            if (m_trap && p_ack) m_trap = 1'b0;
            if (p_iv && p_rdy) begin
                r = ref_decode(p_op);
                if (r[13]) begin
                    sb.push_back({r[12:0], p_tag});
                    m_occ = 1'b1;
                end else begin
                    m_occ  = 1'b0;
                    m_trap = 1'b1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                end
            end else if (m_occ && p_ordy) begin
                m_occ = 1'b0;
            end
        end
        chk("out_valid", 32'(out_valid), 32'(m_occ));
        chk("trap", 32'(trap), 32'(m_trap));
        chk("ill_count", 32'(ill_count), 32'(m_cnt));
        if (p_fl) chk("flushed_ctrl", 32'(dut_cw), 32'd0);
        in_valid  = iv;
        op        = o;
        in_tag    = t;
        flush     = fl;
        out_ready = fl ? 1'b0 : ordy;
        trap_ack  = ack;
        p_rdy  = !m_trap && (!m_occ || out_ready) && !fl;
        p_iv   = iv;
        p_op   = o;
        p_tag  = t;
        p_fl   = fl;
        p_ordy = out_ready;
        p_ack  = ack;
        #1;
        chk("in_ready", 32'(in_ready), 32'(p_rdy));
    endtask

    task automatic model_reset();
        sb.delete();
        m_occ = 1'b0; m_trap = 1'b0; m_cnt = 0;
        p_iv = 1'b0; p_fl = 1'b0; p_ordy = 1'b0; p_ack = 1'b0; p_rdy = 1'b0;
        p_op = '0; p_tag = '0;
    endtask

    // Monitor: compare the held word every cycle it is valid, retire it on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: out_valid=1 with empty scoreboard at %0t", $time);
                end else begin
                    chk("ctrl_word", 32'(dut_cw), 32'(sb[0].cw));
                    chk("out_tag", out_tag, sb[0].tag);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0; trap_ack = 1'b0;
        model_reset();
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl", 32'(dut_cw), 32'd0);
        chk("rst_tag", out_tag, 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_ill_count", 32'(ill_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        step(1, 7'b0000011, 32'h100, 0, 1, 0);
        step(0, 7'b0, 32'h0, 0, 1, 0);
        step(1, 7'b1101111, 32'h104, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 7'b0110011, 32'h108, 0, 0, 0);
        step(1, 7'b0110011, 32'h108, 0, 1, 0);
        step(0, 7'b0, 32'h0, 0, 0, 0);
        step(1, 7'b1101111, 32'h10c, 1, 0, 0);
        step(0, 7'b0, 32'h0, 0, 1, 0);
        step(1, 7'b1111111, 32'h110, 0, 1, 0);
        step(0, 7'b0, 32'h0, 0, 1, 1);
        step(1, 7'b0010111, 32'h114, 0, 1, 0);
        step(0, 7'b0, 32'h0, 0, 1, 1);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, rand_op(), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0);

        step(0, 7'b0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(1, 7'b1111111, 32'(i), 0, 1, 0);
            step(0, 7'b0, 32'h0, 0, 1, 1);
        end

        step(0, 7'b0, 32'h0, 1, 0, 0);
        step(1, 7'b1101111, 32'h200, 0, 1, 0);
        step(0, 7'b0, 32'h0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ctrl", 32'(dut_cw), 32'd0);
        chk("async_rst_ill_count", 32'(ill_count), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++)
            step($urandom_range(0, 1) != 0, rand_op(), $urandom, 1'b0, 1'b1, 1'b1);
        step(0, 7'b0, 32'h0, 0, 1, 1);
        step(0, 7'b0, 32'h0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maindec_stage.md
# maindec_stage

Registered successor to the combinational main decoder for the pipelined RV32I core. It decodes the 7-bit opcode into the control word and holds it in a one-entry valid/ready pipeline register that supports stall and flush. It carries a parametrised payload alongside the control word. Illegal opcodes are detected, counted and raised as a sticky trap that must be acknowledged. It sits between fetch/decode and the D/E register.

## Interface
Parameters:
- OP_WIDTH, 7, opcode width
- TAG_W, 32, width of payload carried with each op (PC or instruction bits)
- CNT_W, 8, width of the saturating illegal-op counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  op/tag presented
- in_ready  out  1  stage accepts this cycle
- op  in  OP_WIDTH  opcode
- in_tag  in  TAG_W  payload
- flush  in  1  synchronous kill of held entry and trap
- out_valid  out  1  registered control word valid
- out_ready  in  1  downstream accepts
- out_tag  out  TAG_W  registered payload
- RegWrite, MemWrite, Jump, Branch, ALUSrc, ALUSrcA  out  1 each  registered controls
- ResultSrc  out  2;  ImmSrc  out  3;  ALUOp  out  2  registered controls
- trap  out  1  illegal opcode pending
- trap_ack  in  1  clears trap
- ill_count  out  CNT_W  illegal ops accepted since reset

## Operation
- Clock is clk; reset is rst_n, asynchronous and active-low.
- ImmSrc encoding: 000 I, 001 S, 010 B, 011 J, 100 U.
- Decode, listed as RegWrite/ResultSrc/MemWrite/Jump/Branch/ALUSrc/ImmSrc/ALUOp, with ALUSrcA=0 unless stated:
  - 0000011 lw: 1/01/0/0/0/1/000/00
  - 0100011 sw: 0/00/1/0/0/1/001/00
  - 0110011 R: 1/00/0/0/0/0/000/10
  - 1100011 B: 0/00/0/0/1/0/010/01
  - 0010011 I-ALU: 1/00/0/0/0/1/000/10
  - 0110111 lui: 1/00/0/0/0/1/100/11
  - 1101111 jal: 1/10/0/1/0/0/011/00
  - 1100111 jalr: 1/10/0/1/0/1/000/00
- 0000000 is a NOP. It is accepted with an all-zero control word and out_valid=1. It is not illegal.
- Any other opcode is illegal:
  - It is accepted but not forwarded, so out_valid goes to 0 as a bubble.
  - The FSM enters TRAP.
  - ill_count increments, saturating at 2^CNT_W-1.
- FSM states RUN and TRAP:
  - RUN→TRAP on acceptance of an illegal op.
  - TRAP→RUN on trap_ack or flush.
  - trap = (state==TRAP).
- in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready. On accept, the register loads the decoded word and in_tag.
- If out_valid && out_ready && !accept, out_valid clears.
- If out_valid && !out_ready, all outputs hold (stall).
- flush has priority over everything:
  - Next cycle: out_valid=0, state=RUN.
  - Control outputs are zeroed; out_tag holds.
  - ill_count is unaffected.
- ill_count is cleared only by reset.

## Timing
- Latency: 1 cycle from accept to out_valid=1.
- Throughput: 1 op/cycle when out_ready=1.
- Reset values:
  - out_valid=0, all control outputs 0, out_tag=0.
  - trap=0, ill_count=0, state=RUN.
  - in_ready reads 1 during reset.
- Simultaneous accept and drain: the new entry replaces the old with no bubble.
- trap_ack while in RUN is ignored.
- Illegal op and trap_ack in the same cycle cannot occur: in TRAP, in_ready=0.
- Reset asserted mid-stall drops the held entry immediately and asynchronously.

## Configuration
- MAINDEC_AUIPC_EN defined:
  - Opcode 0010111 (auipc) decodes as 1/00/0/0/0/1/100/00 with ALUSrcA=1.
- MAINDEC_AUIPC_EN undefined:
  - 0010111 is illegal and raises trap.
  - ALUSrcA is tied to 0.

## Test plan
- Reset, then op=0000011 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, RegWrite=1, ResultSrc=01, ALUSrc=1, ImmSrc=000, ALUOp=00.
- out_ready=0 with jal held, then op=0110011 offered -> in_ready=0, outputs stay jal (ResultSrc=10, Jump=1) until out_ready=1, then R-type loads the next cycle.
- op=1111111 accepted -> out_valid=0, trap=1, ill_count=1, in_ready=0; trap_ack=1 -> trap=0 the next cycle.
- 256 illegal ops (each acked) with CNT_W=8 -> ill_count=255 and stays 255.
- flush=1 while out_valid=1 and stalled, together with in_valid=1 -> next cycle out_valid=0, controls 0, nothing accepted.
- op=0010111 -> with MAINDEC_AUIPC_EN: ALUSrcA=1, ImmSrc=100, trap=0; without it: trap=1, ill_count increments.
